// File: rtl/alu_issue_ctrl.sv
// Instruction fetch/decode, ALU issue and writeback controller for the 8-bit MP datapath.
// Define ALU_CTRL_ILLEGAL_TRAP_EN to halt with a sticky trap on illegal byte0.
module alu_issue_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    input  logic [7:0] instr_data,
    output logic       instr_ready,
    output logic       alu_enable,
    output logic [4:0] alu_opcode,
    output logic [7:0] alu_acc,
    output logic [7:0] alu_operand,
    output logic [7:0] alu_flag,
    input  logic [7:0] alu_result,
    input  logic [7:0] alu_flags,
    output logic [7:0] acc_out,
    output logic [7:0] b_out,
    output logic [7:0] flags_out,
    output logic       busy,
    output logic       done,
    output logic       trap
);

    typedef enum logic [1:0] {
        FETCH0,
        FETCH1,
        EXEC,
        HALT
    } state_t;

    localparam logic [4:0] OP_CMP = 5'h0E;

    state_t     state;
    logic [7:0] byte0;
    logic [7:0] imm_q;
    logic [7:0] acc_q;
    logic [7:0] b_q;
    logic [7:0] flag_q;
    logic       done_q;
    logic       data_legal;

    always_comb begin
        data_legal = 1'b0;
        unique case (instr_data[6:5])
            2'b00:   data_legal = (instr_data[4:0] <= 5'h0E);
            2'b01:   data_legal = instr_data[7];
            2'b10:   data_legal = instr_data[7];
            default: data_legal = 1'b0;
        endcase
    end

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    logic trap_q;
    assign trap = trap_q;
`else
    assign trap = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= FETCH0;
            byte0  <= 8'h00;
            imm_q  <= 8'h00;
            acc_q  <= 8'h00;
            b_q    <= 8'h00;
            flag_q <= 8'h00;
            done_q <= 1'b0;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
            trap_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state)
                FETCH0: begin
                    if (instr_valid) begin
                        if (!data_legal) begin
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
                            trap_q <= 1'b1;
                            state  <= HALT;
`else
                            done_q <= 1'b1;
`endif
                        end else begin
                            byte0 <= instr_data;
                            state <= instr_data[7] ? FETCH1 : EXEC;
                        end
                    end
                end
                FETCH1: begin
                    if (instr_valid) begin
                        imm_q <= instr_data;
                        unique case (byte0[6:5])
                            2'b01: begin
                                acc_q  <= instr_data;
                                done_q <= 1'b1;
                                state  <= FETCH0;
                            end
                            2'b10: begin
                                b_q    <= instr_data;
                                done_q <= 1'b1;
                                state  <= FETCH0;
                            end
                            default: state <= EXEC;
                        endcase
                    end
                end
                EXEC: begin
                    flag_q <= alu_flags;
                    if (byte0[4:0] != OP_CMP)
                        acc_q <= alu_result;
                    done_q <= 1'b1;
                    state  <= FETCH0;
                end
                HALT: state <= HALT;
            endcase
        end
    end

    // Handshake and issue strobes decode straight from the state register.
    assign instr_ready = (state == FETCH0) || (state == FETCH1);
    assign alu_enable  = (state == EXEC);
    assign busy        = (state != FETCH0);
    assign done        = done_q;

    assign alu_opcode  = byte0[4:0];
    assign alu_acc     = acc_q;
    assign alu_operand = byte0[7] ? imm_q : b_q;
    assign alu_flag    = flag_q;

    assign acc_out     = acc_q;
    assign b_out       = b_q;
    assign flags_out   = flag_q;

endmodule
